// File: rtl/multdiv_pkg.sv
// Shared types and sizes for the multiply/divide controller.
package multdiv_pkg;

   localparam int DATA_W = 32;
   localparam int PROD_W = 65;
   localparam int ITER   = 32;
   localparam int CNT_W  = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_e;

   // Unsigned magnitude of a two's-complement word; 0x80000000 maps to itself,
   // which is the correct unsigned magnitude 2^31.
   function automatic logic [DATA_W-1:0] mag32(input logic [DATA_W-1:0] v);
      return v[DATA_W-1] ? (~v + 1'b1) : v;
   endfunction

endpackage

// File: rtl/md_addsub.sv
// 33-bit combinational adder/subtractor shared by the Booth and restoring steps.
module md_addsub (
   input  logic [32:0] a,
   input  logic [32:0] b,
   input  logic        sub,
   output logic [32:0] y
);

   // sub=1 gives a-b, otherwise a+b (two's complement, wraps at 33 bits)
   always_comb begin
      y = sub ? (a - b) : (a + b);
   end

endmodule

// File: rtl/multdiv_ctrl.sv
// Iterative signed multiply (radix-2 Booth) and signed restoring divide.
module multdiv_ctrl
   import multdiv_pkg::*;
(
   input  logic              clock,
   input  logic              reset_n,
   input  logic              ctrl_MULT,
   input  logic              ctrl_DIV,
   input  logic [DATA_W-1:0] data_operandA,
   input  logic [DATA_W-1:0] data_operandB,
   output logic [DATA_W-1:0] data_result,
   output logic              data_exception,
   output logic              data_resultRDY,
   output logic              busy
);

   state_e              state_q, state_d;
   logic [PROD_W-1:0]   p_q, p_d;        // Booth product, or {remainder, quotient}
   logic [DATA_W-1:0]   a_q, a_d;        // multiplicand, or divisor magnitude
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                neg_q, neg_d;    // quotient sign
   logic [DATA_W-1:0]   result_q, result_d;
   logic                exc_q, exc_d;

   logic [32:0]         as_a, as_b, as_y;
   logic                as_sub;
   logic [PROD_W-1:0]   mult_next, div_next;
   logic [DATA_W-1:0]   quot;

   md_addsub u_addsub (
      .a   (as_a),
      .b   (as_b),
      .sub (as_sub),
      .y   (as_y)
   );

   // Route the shared adder and form the next Booth / restoring step values
   always_comb begin
      if (state_q == DIV) begin
         // shift {R,Q} left by one, then trial-subtract the divisor
         as_a   = {p_q[63:32], p_q[31]};
         as_b   = {1'b0, a_q};
         as_sub = 1'b1;
      end else begin
         // sign-extended to 33 bits so the add never loses the true sign before ASR
         as_a   = {p_q[64], p_q[64:33]};
         as_b   = {a_q[DATA_W-1], a_q};
         as_sub = (p_q[1:0] == 2'b10);
      end
      if (p_q[1] ^ p_q[0]) begin
         mult_next = {as_y, p_q[32:1]};
      end else begin
         mult_next = {p_q[64], p_q[64:1]};
      end
      div_next = {(as_y[32] ? as_a : as_y), p_q[30:0], ~as_y[32]};
      quot     = div_next[DATA_W-1:0];
   end

   // Next-state and datapath updates; a start pulse overrides any operation in flight
   always_comb begin
      state_d  = state_q;
      p_d      = p_q;
      a_d      = a_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      result_d = result_q;
      exc_d    = exc_q;
      if (ctrl_MULT) begin
         state_d = MULT;
         p_d     = {32'b0, data_operandB, 1'b0};
         a_d     = data_operandA;
         cnt_d   = '0;
      end else if (ctrl_DIV) begin
         cnt_d = '0;
         if (data_operandB == '0) begin
            state_d  = DONE;
            result_d = '0;
            exc_d    = 1'b1;
         end else begin
            state_d = DIV;
            p_d     = {33'b0, mag32(data_operandA)};
            a_d     = mag32(data_operandB);
            neg_d   = data_operandA[DATA_W-1] ^ data_operandB[DATA_W-1];
         end
      end else begin
         case (state_q)
            MULT: begin
               p_d   = mult_next;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(ITER - 1)) begin
                  state_d  = DONE;
                  cnt_d    = '0;
                  result_d = mult_next[32:1];
                  exc_d    = ~((&mult_next[64:32]) | ~(|mult_next[64:32]));
               end
            end
            DIV: begin
               p_d   = div_next;
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(ITER - 1)) begin
                  state_d  = DONE;
                  cnt_d    = '0;
                  result_d = neg_q ? (~quot + 1'b1) : quot;
                  // only +2^31 (e.g. 0x80000000 / -1) is unrepresentable
                  exc_d    = ~neg_q & quot[DATA_W-1];
               end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // State and datapath registers, cleared asynchronously
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         p_q      <= '0;
         a_q      <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         result_q <= '0;
         exc_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         p_q      <= p_d;
         a_q      <= a_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         result_q <= result_d;
         exc_q    <= exc_d;
      end
   end

   assign data_result    = result_q;
   assign data_exception = exc_q;
   assign data_resultRDY = (state_q == DONE);
   assign busy           = (state_q == MULT) || (state_q == DIV);

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed self-checking bench for multdiv_ctrl.
module tb_multdiv_ctrl;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        ctrl_MULT = 1'b0;
   logic        ctrl_DIV = 1'b0;
   logic [31:0] data_operandA = '0;
   logic [31:0] data_operandB = '0;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_resultRDY;
   logic        busy;

   int total = 0;
   int bad = 0;
   int rdy_cnt = 0;
   int lat;

   multdiv_ctrl dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY),
      .busy           (busy)
   );

   always #5 clock = ~clock;

   // count completion pulses, sampled away from the active edge
   always @(negedge clock) if (data_resultRDY === 1'b1) rdy_cnt++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // drive a start pulse; returns just after the edge that samples it
   task automatic start(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      ctrl_MULT = m;
      ctrl_DIV = d;
      data_operandA = a;
      data_operandB = b;
      @(posedge clock);
      #1;
      ctrl_MULT = 1'b0;
      ctrl_DIV = 1'b0;
   endtask

   // n counts edges from the sampling edge (that edge = 1) until resultRDY is seen
   task automatic wait_rdy(output int n);
      n = 1;
      while (data_resultRDY !== 1'b1 && n < 60) begin
         @(posedge clock);
         n++;
         #1;
      end
   endtask

   task automatic op(input string tag, input logic m, input logic d, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] er, input logic ee, input int el);
      int n;
      start(m, d, a, b);
      wait_rdy(n);
      chk({tag, "_lat"}, 32'(n), 32'(el));
      chk({tag, "_res"}, data_result, er);
      chk({tag, "_exc"}, {31'b0, data_exception}, {31'b0, ee});
      chk({tag, "_busy_done"}, {31'b0, busy}, 32'd0);
      @(posedge clock);
      #1;
      chk({tag, "_pulse1"}, {31'b0, data_resultRDY}, 32'd0);
      chk({tag, "_hold"}, data_result, er);
   endtask

   initial begin
      // reset state
      #1;
      chk("rst_res", data_result, 32'd0);
      chk("rst_exc", {31'b0, data_exception}, 32'd0);
      chk("rst_rdy", {31'b0, data_resultRDY}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      @(negedge clock);
      @(negedge clock);
      reset_n = 1'b1;

      // 7 * -3, single pulse counted
      rdy_cnt = 0;
      start(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
      chk("m73_busy", {31'b0, busy}, 32'd1);
      wait_rdy(lat);
      chk("m73_lat", 32'(lat), 32'd33);
      chk("m73_res", data_result, 32'hFFFF_FFEB);
      chk("m73_exc", {31'b0, data_exception}, 32'd0);
      repeat (3) @(posedge clock);
      #1;
      chk("m73_one_pulse", 32'(rdy_cnt), 32'd1);

      op("m_ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1, 33);
      op("m_min1", 1'b1, 1'b0, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, 33);
      op("m_minm1", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33);
      op("d_m7_2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 33);
      op("d_10_0", 1'b0, 1'b1, 32'd10, 32'd0, 32'd0, 1'b1, 1);
      op("d_min_m1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33);
      op("d_m100_7", 1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 1'b0, 33);
      op("d_7_m100", 1'b0, 1'b1, 32'd7, 32'hFFFF_FF9C, 32'd0, 1'b0, 33);
      op("both_6_3", 1'b1, 1'b1, 32'd6, 32'd3, 32'd18, 1'b0, 33);

      // abort: multiply, then divide 100/7 at iteration 10
      rdy_cnt = 0;
      start(1'b1, 1'b0, 32'd9, 32'd9);
      repeat (9) @(posedge clock);
      start(1'b0, 1'b1, 32'd100, 32'd7);
      chk("abort_hold", data_result, 32'd18);
      wait_rdy(lat);
      chk("abort_lat", 32'(lat), 32'd33);
      chk("abort_res", data_result, 32'd14);
      repeat (3) @(posedge clock);
      #1;
      chk("abort_pulses", 32'(rdy_cnt), 32'd1);

      // reset in the middle of a multiply
      rdy_cnt = 0;
      start(1'b1, 1'b0, 32'd3, 32'd4);
      repeat (19) @(posedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      chk("mrst_res", data_result, 32'd0);
      chk("mrst_exc", {31'b0, data_exception}, 32'd0);
      chk("mrst_busy", {31'b0, busy}, 32'd0);
      repeat (40) @(posedge clock);
      #1;
      chk("mrst_no_rdy", 32'(rdy_cnt), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      op("m_5_5", 1'b1, 1'b0, 32'd5, 32'd5, 32'd25, 1'b0, 33);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
